fpu_config_fetcher: RTL and testbench
=====================================

# fpu_config_fetcher

Parametrised configuration fetcher for the FPU controller. On a start request it reads a programmable-size convolution filter, image dimensions, source address and result address from the memory-mapped configuration region through a request/valid handshake. It stages them in shadow registers and commits them atomically to the FPU datapath on completion. It supports any odd filter size and an optional per-word timeout watchdog.

## Interface
Parameters:
- FILTER_DIM, 3: filter side length; NTAPS = FILTER_DIM², 8-bit taps
- DATA_W, 32: memory word width; fixed at 32, 4 taps per word
- ADDR_W, 32: memory address width
- FILTER_BASE, 32'h1000_0040: address of first filter word
- DIMS_BASE, 32'h1000_0000: address of the {width, height} word
- START_BASE, 32'h1000_0020: address of the image start-address word
- RESULT_BASE, 32'h1000_0100: address of the result-address word
- TIMEOUT_CYCLES, 256: per-word wait limit; used only with the macro

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset; asynchronous, active-high
- load_start  in  1  start fetch; sampled in IDLE/ERROR only
- abort  in  1  cancel in-progress fetch
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  read address; held stable while mem_req is high
- mem_data  in  DATA_W  read data; valid with mem_valid
- mem_valid  in  1  word accepted on a cycle where mem_req && mem_valid
- busy  out  1  high in FETCH
- done  out  1  one-cycle pulse when the commit happens
- error  out  1  timeout flag; sticky until the next load_start
- filter  out  NTAPS×8  packed taps; tap k at [8k+7:8k]
- image_width, image_height  out  16 each
- start_address, result_address  out  32 each

## Operation
- FW = ceil(NTAPS/4). Word sequence index w = 0..FW+2:
  - words 0..FW-1 are filter words at FILTER_BASE+4w
  - word FW is at DIMS_BASE
  - word FW+1 is at START_BASE
  - word FW+2 is at RESULT_BASE
- Filter word w: tap 4w+j = mem_data[31-8j -: 8], so the MSB byte holds the lowest tap. Bytes past NTAPS in the last word are discarded.
- Dims word: image_width = mem_data[31:16], image_height = mem_data[15:0].
- States:
  - IDLE: if load_start, then w = 0 and go to FETCH.
  - FETCH: on acceptance, write the shadow register and increment w. After the last word, go to COMMIT. If abort, go to IDLE.
  - COMMIT: copy shadows to outputs, pulse done, go to IDLE.
  - ERROR: only with the macro. If load_start, clear error and go to FETCH.
- Outputs change only in COMMIT. An abort or a timeout leaves the previous configuration intact.
- Boundary cases:
  - load_start in FETCH or COMMIT is ignored.
  - mem_valid while mem_req is low is ignored.
  - abort and acceptance in the same cycle: abort wins and the word is discarded.
  - abort outside FETCH has no effect.

## Timing
- Reset values: state IDLE; mem_req 0; mem_addr FILTER_BASE; busy, done and error 0; all configuration outputs and shadows 0.
- load_start high at cycle 0 gives mem_req = 1 at cycle 1.
- mem_req stays high through FETCH. mem_addr advances on the edge after each acceptance, so a zero-wait memory delivers one word per cycle.
- With zero-wait memory, done is high at cycle FW+4. For FILTER_DIM=3 that is cycle 7. The new outputs are visible in the same cycle as done.
- mem_req drops on the edge after the last acceptance.
- abort: mem_req and busy are low on the next cycle.
- Reset asserted mid-operation returns to the reset values immediately, asynchronously.

## Configuration
Macro: FPU_CFG_TIMEOUT_EN.
- Defined:
  - A counter restarts on every acceptance and on entry to FETCH.
  - If TIMEOUT_CYCLES consecutive FETCH cycles pass with no acceptance, go to ERROR.
  - In ERROR: mem_req 0, busy 0, error 1, no done pulse.
- Undefined:
  - FETCH waits indefinitely.
  - error is tied to 0.
  - ERROR is unreachable and no counter is synthesised.

## Structure
- Shared package fpu_cfg_pkg holds:
  - the state enum
  - default base-address constants
  - the FW/NTAPS derivation functions
  - the tap and dims widths
- Sub-module fpu_cfg_tap_unpack: combinational extraction of the 4 taps from one word, with a byte-valid mask for the partial last word. It is instantiated once.

## Test plan
- Config FILTER_DIM=3, zero-wait memory:
  - Stimulus: filter words 0x01020304, 0x05060708, 0x09AABBCC; dims 0x0280_01E0; start 0x2000_0000; result 0x3000_0000.
  - Response: taps 1..9 in order; 0xAA/0xBB/0xCC discarded; width 640, height 480; done at cycle 7.
- Config FILTER_DIM=5 (FW=7), 3-cycle memory latency per word:
  - Response: addresses sequence 0x1000_0040..0x1000_0058, then 0x1000_0000, 0x1000_0020, 0x1000_0100; 25 taps correct.
  - Response: mem_addr is stable while waiting for mem_valid.
- abort during word 2 of a second fetch:
  - Response: outputs keep the first configuration; no done pulse; busy low the next cycle.
- load_start pulsed again mid-fetch:
  - Response: it is ignored; the word sequence is uninterrupted.
- FPU_CFG_TIMEOUT_EN with TIMEOUT_CYCLES=16, mem_valid withheld at word 4:
  - Response: error rises after 16 cycles with mem_req 0; outputs unchanged.
  - Response: a following load_start clears error and the fetch completes.
- rst asserted mid-fetch:
  - Response: all outputs are 0 immediately; the first cycle after release is idle, with mem_req 0.

Source files
------------

// File: rtl/fpu_cfg_pkg.sv
// fpu_config_fetcher shared package: FSM states,
// default base addresses and filter geometry helpers.
package fpu_cfg_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_COMMIT,
    S_ERROR
  } cfg_state_e;

  localparam logic [31:0] DEF_FILTER_BASE = 32'h1000_0040;
  localparam logic [31:0] DEF_DIMS_BASE   = 32'h1000_0000;
  localparam logic [31:0] DEF_START_BASE  = 32'h1000_0020;
  localparam logic [31:0] DEF_RESULT_BASE = 32'h1000_0100;

  localparam int TAP_W         = 8;
  localparam int DIM_W         = 16;
  localparam int TAPS_PER_WORD = 4;

  function automatic int cfg_ntaps(int fd);
    return fd * fd;
  endfunction

  function automatic int cfg_fw(int fd);
    return (fd * fd + TAPS_PER_WORD - 1) / TAPS_PER_WORD;
  endfunction

endpackage

// File: rtl/fpu_cfg_mem_if.sv
// Configuration-region read port: request/valid
// handshake between the fetcher and memory.
interface fpu_cfg_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_valid;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_data,
    input  mem_valid
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_data,
    output mem_valid
  );

endinterface

// File: rtl/fpu_cfg_tap_unpack.sv
// Splits one config word into 4 taps, MSB byte first,
// and masks bytes beyond NTAPS in the last filter word.
module fpu_cfg_tap_unpack
  import fpu_cfg_pkg::*;
#(
  parameter int NTAPS = 9
) (
  input  logic [31:0]                        word,
  input  logic                               last,
  output logic [TAPS_PER_WORD-1:0][TAP_W-1:0] taps,
  output logic [TAPS_PER_WORD-1:0]           byte_vld
);

  localparam int FW  = (NTAPS + TAPS_PER_WORD - 1) / TAPS_PER_WORD;
  localparam int REM = NTAPS - TAPS_PER_WORD * (FW - 1);

  // byte j of the word is tap j; only REM bytes live in the last word
  always_comb begin
    taps     = '0;
    byte_vld = '0;
    for (int j = 0; j < TAPS_PER_WORD; j++) begin
      taps[j]     = word[31-8*j -: 8];
      byte_vld[j] = !last || (j < REM);
    end
  end

endmodule

// File: rtl/fpu_config_fetcher.sv
// FPU config fetcher: reads filter/dims/addresses into shadows,
// commits atomically. FPU_CFG_TIMEOUT_EN adds a per-word watchdog.
module fpu_config_fetcher
  import fpu_cfg_pkg::*;
#(
  parameter int              FILTER_DIM     = 3,
  parameter int              DATA_W         = 32,
  parameter int              ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] FILTER_BASE  = DEF_FILTER_BASE,
  parameter logic [ADDR_W-1:0] DIMS_BASE    = DEF_DIMS_BASE,
  parameter logic [ADDR_W-1:0] START_BASE   = DEF_START_BASE,
  parameter logic [ADDR_W-1:0] RESULT_BASE  = DEF_RESULT_BASE,
  parameter int              TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 abort,
  fpu_cfg_mem_if.master        mem,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [FILTER_DIM*FILTER_DIM*TAP_W-1:0] filter,
  output logic [DIM_W-1:0]     image_width,
  output logic [DIM_W-1:0]     image_height,
  output logic [31:0]          start_address,
  output logic [31:0]          result_address
);

  localparam int NTAPS = cfg_ntaps(FILTER_DIM);
  localparam int FW    = cfg_fw(FILTER_DIM);
  localparam int LASTW = FW + 2;
  localparam int WW    = $clog2(FW + 3);

  cfg_state_e state_q, state_d;
  logic [WW-1:0] w_q, w_d;

  logic [DATA_W-1:0] rd;
  logic acc, take, last_take, tmo_hit;

  logic [NTAPS-1:0][TAP_W-1:0] sh_tap_q;
  logic [31:0] sh_dims_q;
  logic [31:0] sh_start_q;

  logic [TAPS_PER_WORD-1:0][TAP_W-1:0] taps;
  logic [TAPS_PER_WORD-1:0]            bvld;

  assign rd        = mem.mem_data;
  assign mem.mem_req = (state_q == S_FETCH);
  assign busy      = (state_q == S_FETCH);
  assign done      = (state_q == S_COMMIT);
  assign acc       = mem.mem_req && mem.mem_valid;
  assign take      = acc && !abort;
  assign last_take = take && (w_q == WW'(LASTW));

  fpu_cfg_tap_unpack #(
    .NTAPS (NTAPS)
  ) u_unpack (
    .word     (rd[31:0]),
    .last     (w_q == WW'(FW - 1)),
    .taps     (taps),
    .byte_vld (bvld)
  );

`ifdef FPU_CFG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  assign tmo_hit = (state_q == S_FETCH) && !acc &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign error   = (state_q == S_ERROR);

  // idle-cycle watchdog; zero outside FETCH so entry restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (state_q != S_FETCH || acc) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign error   = 1'b0;
`endif

  // word-index decode to the config-region address
  always_comb begin
    mem.mem_addr = FILTER_BASE;
    unique case (1'b1)
      (w_q < WW'(FW)):
        mem.mem_addr = FILTER_BASE + ADDR_W'({w_q, 2'b00});
      (w_q == WW'(FW)):
        mem.mem_addr = DIMS_BASE;
      (w_q == WW'(FW + 1)):
        mem.mem_addr = START_BASE;
      default:
        mem.mem_addr = RESULT_BASE;
    endcase
  end

  // state and word index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
    end
  end

  // next state: abort beats acceptance, acceptance beats timeout
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (load_start) begin
          state_d = S_FETCH;
          w_d     = '0;
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
          w_d     = '0;
        end else if (acc) begin
          if (w_q == WW'(LASTW)) begin
            state_d = S_COMMIT;
            w_d     = '0;
          end else begin
            w_d = w_q + 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = S_ERROR;
          w_d     = '0;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        w_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        w_d     = '0;
      end
    endcase
  end

  // shadow capture of each accepted word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_tap_q   <= '0;
      sh_dims_q  <= '0;
      sh_start_q <= '0;
    end else if (take) begin
      for (int k = 0; k < NTAPS; k++) begin
        if (w_q == WW'(k / TAPS_PER_WORD) &&
            bvld[k % TAPS_PER_WORD]) begin
          sh_tap_q[k] <= taps[k % TAPS_PER_WORD];
        end
      end
      if (w_q == WW'(FW)) begin
        sh_dims_q <= rd[31:0];
      end
      if (w_q == WW'(FW + 1)) begin
        sh_start_q <= rd[31:0];
      end
    end
  end

  // atomic commit, landing in the same cycle done is high;
  // the result word is the last one and bypasses the shadows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filter         <= '0;
      image_width    <= '0;
      image_height   <= '0;
      start_address  <= '0;
      result_address <= '0;
    end else if (last_take) begin
      filter         <= sh_tap_q;
      image_width    <= sh_dims_q[31:16];
      image_height   <= sh_dims_q[15:0];
      start_address  <= sh_start_q;
      result_address <= rd[31:0];
    end
  end

endmodule

// File: tb/tb_fpu_config_fetcher.sv
// Directed bench for fpu_config_fetcher: 3x3 zero-wait and
// 5x5 three-cycle-latency memories, abort, restart, reset.
module tb_fpu_config_fetcher;

  logic clk = 1'b0;
  logic rst;
  logic ls3, ab3, ls5, ab5;
  logic hold;
  logic sel;
  logic [1:0] lat;

  logic busy3, done3, err3;
  logic [71:0] filt3;
  logic [15:0] w3, h3;
  logic [31:0] st3, rs3;

  logic busy5, done5, err5;
  logic [199:0] filt5;
  logic [15:0] w5, h5;
  logic [31:0] st5, rs5;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int bad;
  int ndone;
  logic [31:0] acc_q[$];

  always #5 clk = ~clk;

  fpu_cfg_mem_if m3 ();
  fpu_cfg_mem_if m5 ();

  function automatic logic [31:0] word3(logic [31:0] a, logic s);
    case (a)
      32'h1000_0040: return s ? 32'h1112_1314 : 32'h0102_0304;
      32'h1000_0044: return s ? 32'h1516_1718 : 32'h0506_0708;
      32'h1000_0048: return s ? 32'h1900_0000 : 32'h09AA_BBCC;
      32'h1000_0000: return s ? 32'h0320_0258 : 32'h0280_01E0;
      32'h1000_0020: return s ? 32'h2100_0000 : 32'h2000_0000;
      32'h1000_0100: return s ? 32'h3100_0000 : 32'h3000_0000;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] word5(logic [31:0] a);
    logic [7:0] b;
    if (a >= 32'h1000_0040 && a < 32'h1000_005C) begin
      b = 8'((a - 32'h1000_0040) >> 2);
      return {8'(4*b+1), 8'(4*b+2), 8'(4*b+3), 8'(4*b+4)};
    end
    case (a)
      32'h1000_0000: return 32'h0100_0080;
      32'h1000_0020: return 32'h4000_0000;
      32'h1000_0100: return 32'h5000_0010;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [71:0] exp3(logic s);
    logic [71:0] f = '0;
    for (int k = 0; k < 9; k++)
      f[8*k +: 8] = s ? 8'(8'h11 + k) : 8'(k + 1);
    return f;
  endfunction

  function automatic logic [199:0] exp5();
    logic [199:0] f = '0;
    for (int k = 0; k < 25; k++)
      f[8*k +: 8] = 8'(k + 1);
    return f;
  endfunction

  function automatic logic [31:0] addr3(int i);
    if (i < 3) return 32'h1000_0040 + 32'(4*i);
    if (i == 3) return 32'h1000_0000;
    if (i == 4) return 32'h1000_0020;
    return 32'h1000_0100;
  endfunction

  function automatic logic [31:0] addr5(int i);
    if (i < 7) return 32'h1000_0040 + 32'(4*i);
    if (i == 7) return 32'h1000_0000;
    if (i == 8) return 32'h1000_0020;
    return 32'h1000_0100;
  endfunction

  assign m3.mem_valid = m3.mem_req &&
                        !(hold && m3.mem_addr == 32'h1000_0020);
  assign m3.mem_data  = word3(m3.mem_addr, sel);

  assign m5.mem_valid = m5.mem_req && (lat == 2'd2);
  assign m5.mem_data  = word5(m5.mem_addr);

  always @(posedge clk)
    lat <= (m5.mem_req && lat != 2'd2) ? lat + 2'd1 : 2'd0;

  fpu_config_fetcher #(
    .FILTER_DIM     (3),
    .TIMEOUT_CYCLES (16)
  ) dut3 (
    .clk            (clk),
    .rst            (rst),
    .load_start     (ls3),
    .abort          (ab3),
    .mem            (m3),
    .busy           (busy3),
    .done           (done3),
    .error          (err3),
    .filter         (filt3),
    .image_width    (w3),
    .image_height   (h3),
    .start_address  (st3),
    .result_address (rs3)
  );

  fpu_config_fetcher #(
    .FILTER_DIM (5)
  ) dut5 (
    .clk            (clk),
    .rst            (rst),
    .load_start     (ls5),
    .abort          (ab5),
    .mem            (m5),
    .busy           (busy5),
    .done           (done5),
    .error          (err5),
    .filter         (filt5),
    .image_width    (w5),
    .image_height   (h5),
    .start_address  (st5),
    .result_address (rs5)
  );

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // start a 3x3 fetch, optionally re-pulse load_start at a cycle,
  // log accepted addresses, stop at done or after 30 cycles
  task automatic run3(input int pulse_at, output int c);
    acc_q.delete();
    @(negedge clk) ls3 = 1'b1;
    @(negedge clk) ls3 = 1'b0;
    c = 1;
    while (!done3 && c < 30) begin
      if (m3.mem_req && m3.mem_valid) acc_q.push_back(m3.mem_addr);
      ls3 = (c == pulse_at);
      @(negedge clk);
      c++;
    end
    ls3 = 1'b0;
  endtask

  task automatic chk_seq3(input string tag);
    bad = 0;
    for (int i = 0; i < acc_q.size() && i < 6; i++)
      if (acc_q[i] !== addr3(i)) bad++;
    chk({tag, "_n"}, 256'(acc_q.size()), 256'd6);
    chk({tag, "_addr"}, 256'(bad), 256'd0);
  endtask

  initial begin
    rst = 1'b1; ls3 = 0; ab3 = 0; ls5 = 0; ab5 = 0;
    hold = 0; sel = 0;
    repeat (3) @(negedge clk);
    chk("rst_req", m3.mem_req, 1'b0);
    chk("rst_addr", m3.mem_addr, 32'h1000_0040);
    chk("rst_busy", busy3, 1'b0);
    chk("rst_done", done3, 1'b0);
    chk("rst_err", err3, 1'b0);
    chk("rst_filt", filt3, 72'h0);
    chk("rst_dims", {w3, h3, st3, rs3}, 96'h0);
    rst = 1'b0;
    @(negedge clk);

    // 3x3 zero-wait fetch
    @(negedge clk) ls3 = 1'b1;
    @(negedge clk) ls3 = 1'b0;
    chk("t1_req_c1", m3.mem_req, 1'b1);
    chk("t1_busy_c1", busy3, 1'b1);
    cyc = 1; acc_q.delete();
    while (!done3 && cyc < 30) begin
      if (m3.mem_req && m3.mem_valid) acc_q.push_back(m3.mem_addr);
      @(negedge clk);
      cyc++;
    end
    chk("t1_done_cyc", 256'(cyc), 256'd7);
    chk("t1_req_off", m3.mem_req, 1'b0);
    chk("t1_filt", filt3, exp3(1'b0));
    chk("t1_width", w3, 16'd640);
    chk("t1_height", h3, 16'd480);
    chk("t1_start", st3, 32'h2000_0000);
    chk("t1_result", rs3, 32'h3000_0000);
    chk_seq3("t1_seq");
    @(negedge clk);
    chk("t1_done_pulse", done3, 1'b0);

    // abort during word 2 of a second fetch
    sel = 1'b1;
    @(negedge clk) ls3 = 1'b1;
    @(negedge clk) ls3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t2_addr_w2", m3.mem_addr, 32'h1000_0048);
    ab3 = 1'b1;
    @(negedge clk) ab3 = 1'b0;
    chk("t2_req", m3.mem_req, 1'b0);
    chk("t2_busy", busy3, 1'b0);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done3) ndone++;
    end
    chk("t2_no_done", 256'(ndone), 256'd0);
    chk("t2_filt", filt3, exp3(1'b0));
    chk("t2_dims", {w3, h3, st3, rs3},
        {16'd640, 16'd480, 32'h2000_0000, 32'h3000_0000});

    // load_start re-pulsed mid-fetch is ignored
    run3(3, cyc);
    chk("t3_done_cyc", 256'(cyc), 256'd7);
    chk_seq3("t3_seq");
    chk("t3_filt", filt3, exp3(1'b1));
    chk("t3_dims", {w3, h3, st3, rs3},
        {16'd800, 16'd600, 32'h2100_0000, 32'h3100_0000});

    // 5x5 with three-cycle memory latency
    acc_q.delete();
    bad = 0;
    @(negedge clk) ls5 = 1'b1;
    @(negedge clk) ls5 = 1'b0;
    cyc = 1;
    begin
      logic pend;
      logic [31:0] paddr;
      pend = 1'b0; paddr = '0;
      while (!done5 && cyc < 200) begin
        if (m5.mem_req) begin
          if (pend && m5.mem_addr !== paddr) bad++;
          if (m5.mem_valid) begin
            acc_q.push_back(m5.mem_addr);
            pend = 1'b0;
          end else begin
            pend = 1'b1;
            paddr = m5.mem_addr;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk("t5_addr_stable", 256'(bad), 256'd0);
    chk("t5_done_cyc", 256'(cyc), 256'd31);
    chk("t5_n", 256'(acc_q.size()), 256'd10);
    bad = 0;
    for (int i = 0; i < acc_q.size() && i < 10; i++)
      if (acc_q[i] !== addr5(i)) bad++;
    chk("t5_seq", 256'(bad), 256'd0);
    chk("t5_filt", filt5, exp5());
    chk("t5_dims", {w5, h5, st5, rs5},
        {16'd256, 16'd128, 32'h4000_0000, 32'h5000_0010});

    // stall at word 4 (start address)
    sel = 1'b0;
    hold = 1'b1;
    @(negedge clk) ls3 = 1'b1;
    @(negedge clk) ls3 = 1'b0;
    cyc = 1; ndone = 0;
`ifdef FPU_CFG_TIMEOUT_EN
    while (!err3 && cyc < 60) begin
      if (done3) ndone++;
      @(negedge clk);
      cyc++;
    end
    chk("t4_err_cyc", 256'(cyc), 256'd21);
    chk("t4_err", err3, 1'b1);
    chk("t4_req", m3.mem_req, 1'b0);
    chk("t4_busy", busy3, 1'b0);
    chk("t4_no_done", 256'(ndone), 256'd0);
    chk("t4_filt_keep", filt3, exp3(1'b1));
    repeat (3) @(negedge clk);
    chk("t4_err_sticky", err3, 1'b1);
    hold = 1'b0;
    run3(-1, cyc);
    chk("t4_rerun_cyc", 256'(cyc), 256'd7);
    chk("t4_err_clr", err3, 1'b0);
`else
    repeat (40) begin
      if (done3) ndone++;
      @(negedge clk);
    end
    chk("t4_err_tied", err3, 1'b0);
    chk("t4_busy_wait", busy3, 1'b1);
    chk("t4_addr_wait", m3.mem_addr, 32'h1000_0020);
    chk("t4_no_done", 256'(ndone), 256'd0);
    hold = 1'b0;
    cyc = 0;
    while (!done3 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("t4_resume_cyc", 256'(cyc), 256'd2);
`endif
    chk("t4_filt", filt3, exp3(1'b0));
    chk("t4_dims", {w3, h3, st3, rs3},
        {16'd640, 16'd480, 32'h2000_0000, 32'h3000_0000});

    // asynchronous reset mid-fetch
    sel = 1'b1;
    @(negedge clk) ls3 = 1'b1;
    @(negedge clk) ls3 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_req", m3.mem_req, 1'b0);
    chk("t6_busy", busy3, 1'b0);
    chk("t6_addr", m3.mem_addr, 32'h1000_0040);
    chk("t6_filt", filt3, 72'h0);
    chk("t6_dims", {w3, h3, st3, rs3}, 96'h0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("t6_idle_req", m3.mem_req, 1'b0);
    chk("t6_idle_busy", busy3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
